// File: rtl/redirect_route_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : redirect_route_ctrl
// Description : Turns per-target-port redirect requests into per-initiator
//               route overrides for the AXI crossbar. An override is written
//               only after the affected initiator has been quiesced.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                  : clock
//   rst_n                : asynchronous active-low reset
//   redirect_valid_i     : per target port, level request (high = redirect on)
//   source_i             : per target port, initiator to redirect (packed)
//   target_i             : per target port, new destination index (packed)
//   quiesce_req_o        : per initiator, stall new AW/AR
//   quiesce_ack_i        : per initiator, stalled and drained
//   route_override_en_o  : per initiator, override active
//   route_override_tgt_o : per initiator, override destination (packed)
//   busy_o               : controller is servicing a request
//   conflict_o           : 1-cycle pulse, an install took another port's entry
//   err_timeout_o        : sticky, a drain timed out or a source was invalid
// ============================================================================
module redirect_route_ctrl #(
    parameter int N_TARG_PORT   = 7,
    parameter int N_INIT_PORT   = 4,
    parameter int LOG_N_INIT    = 2,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_TARG_PORT-1:0]            redirect_valid_i,
    input  logic [N_TARG_PORT*LOG_N_INIT-1:0] source_i,
    input  logic [N_TARG_PORT*LOG_N_INIT-1:0] target_i,
    output logic [N_INIT_PORT-1:0]            quiesce_req_o,
    input  logic [N_INIT_PORT-1:0]            quiesce_ack_i,
    output logic [N_INIT_PORT-1:0]            route_override_en_o,
    output logic [N_INIT_PORT*LOG_N_INIT-1:0] route_override_tgt_o,
    output logic                              busy_o,
    output logic                              conflict_o,
    output logic                              err_timeout_o
);

    localparam int c_pw = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1;
    localparam int c_tw = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_timeout = c_tw'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUIESCE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;

    logic [N_TARG_PORT-1:0]  r_valid_q;
    logic [N_TARG_PORT-1:0]  r_inst_pend;
    logic [N_TARG_PORT-1:0]  r_rem_pend;
    logic [LOG_N_INIT-1:0]   r_src_sh [N_TARG_PORT];
    logic [LOG_N_INIT-1:0]   r_tgt_sh [N_TARG_PORT];

    // Operation currently being serviced
    logic                    r_op_inst;
    logic [c_pw-1:0]         r_p;
    logic [LOG_N_INIT-1:0]   r_src;
    logic [LOG_N_INIT-1:0]   r_tgt;
    logic [c_tw-1:0]         r_timer;

    // Route table
    logic [N_INIT_PORT-1:0]  r_en;
    logic [LOG_N_INIT-1:0]   r_tbl_tgt [N_INIT_PORT];
    logic [c_pw-1:0]         r_owner   [N_INIT_PORT];

    logic                    r_conflict;
    logic                    r_err;

    logic                    w_any;
    logic [c_pw-1:0]         w_pick_p;
    logic                    w_pick_inst;
    logic [LOG_N_INIT-1:0]   w_pick_src;
    logic                    w_start;
    logic                    w_discard;
    logic                    w_commit;
    logic                    w_timeout;
    logic                    w_tmr_inc;

    // Lowest pending port wins; descending scan lets the lowest index overwrite.
    // Install is chosen over remove on the same port.
    always_comb begin
        w_any       = 1'b0;
        w_pick_p    = '0;
        w_pick_inst = 1'b0;
        for (int p = N_TARG_PORT - 1; p >= 0; p--) begin
            if (r_inst_pend[p] || r_rem_pend[p]) begin
                w_any       = 1'b1;
                w_pick_p    = c_pw'(p);
                w_pick_inst = r_inst_pend[p];
            end
        end
    end

    assign w_pick_src = r_src_sh[w_pick_p];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_discard   = 1'b0;
        w_commit    = 1'b0;
        w_timeout   = 1'b0;
        w_tmr_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    // A source with no initiator behind it is dropped without quiescing
                    if (int'(w_pick_src) >= N_INIT_PORT) begin
                        w_discard = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = S_QUIESCE;
                    end
                end
            end
            S_QUIESCE: begin
                if (quiesce_ack_i[r_src]) begin
                    w_state_nxt = S_COMMIT;
                end else if (r_timer == c_timeout) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q   <= '0;
            r_inst_pend <= '0;
            r_rem_pend  <= '0;
            r_op_inst   <= 1'b0;
            r_p         <= '0;
            r_src       <= '0;
            r_tgt       <= '0;
            r_timer     <= '0;
            r_en        <= '0;
            r_conflict  <= 1'b0;
            r_err       <= 1'b0;
            for (int p = 0; p < N_TARG_PORT; p++) begin
                r_src_sh[p] <= '0;
                r_tgt_sh[p] <= '0;
            end
            for (int i = 0; i < N_INIT_PORT; i++) begin
                r_tbl_tgt[i] <= '0;
                r_owner[i]   <= '0;
            end
        end else begin
            r_valid_q  <= redirect_valid_i;
            r_conflict <= 1'b0;

            if (w_start || w_discard) begin
                if (w_pick_inst) r_inst_pend[w_pick_p] <= 1'b0;
                else             r_rem_pend[w_pick_p]  <= 1'b0;
            end

            if (w_start) begin
                r_op_inst <= w_pick_inst;
                r_p       <= w_pick_p;
                r_src     <= w_pick_src;
                r_tgt     <= r_tgt_sh[w_pick_p];
                r_timer   <= '0;
            end

            if (w_tmr_inc)              r_timer <= r_timer + 1'b1;
            if (w_discard || w_timeout) r_err   <= 1'b1;

            if (w_commit) begin
                if (r_op_inst) begin
                    r_en[r_src]      <= 1'b1;
                    r_tbl_tgt[r_src] <= r_tgt;
                    r_owner[r_src]   <= r_p;
                    if (r_en[r_src] && (r_owner[r_src] != r_p)) r_conflict <= 1'b1;
                end else if (r_en[r_src] && (r_owner[r_src] == r_p)) begin
                    // Only the owning port may withdraw an entry
                    r_en[r_src] <= 1'b0;
                end
            end

            // Edges are applied after the service clear so a fresh edge is never lost
            for (int p = 0; p < N_TARG_PORT; p++) begin
                if (redirect_valid_i[p] && !r_valid_q[p]) begin
                    r_inst_pend[p] <= 1'b1;
                    r_rem_pend[p]  <= 1'b0;
                    r_src_sh[p]    <= source_i[p*LOG_N_INIT +: LOG_N_INIT];
                    r_tgt_sh[p]    <= target_i[p*LOG_N_INIT +: LOG_N_INIT];
                end else if (!redirect_valid_i[p] && r_valid_q[p]) begin
                    r_rem_pend[p]  <= 1'b1;
                    r_inst_pend[p] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        quiesce_req_o = '0;
        if (r_state == S_QUIESCE || r_state == S_COMMIT) quiesce_req_o[r_src] = 1'b1;
    end

    generate
        for (genvar i = 0; i < N_INIT_PORT; i++) begin : g_tgt_out
            assign route_override_tgt_o[i*LOG_N_INIT +: LOG_N_INIT] = r_tbl_tgt[i];
        end
    endgenerate

    assign route_override_en_o = r_en;
    assign busy_o              = (r_state != S_IDLE);
    assign conflict_o          = r_conflict;
    assign err_timeout_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_redirect_route_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_redirect_route_ctrl
// Description : Self-checking bench for redirect_route_ctrl. A request-level
//               model predicts every output each cycle; directed scenarios
//               add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redirect_route_ctrl;

    localparam int NT = 7;
    localparam int NI = 4;
    localparam int LW = 2;
    localparam int TO = 5;

    logic              clk;
    logic              rst_n;
    logic [NT-1:0]     vld;
    logic [NT*LW-1:0]  src_v;
    logic [NT*LW-1:0]  tgt_v;
    logic [NI-1:0]     ack;
    logic [NI-1:0]     q_req;
    logic [NI-1:0]     ov_en;
    logic [NI*LW-1:0]  ov_tgt;
    logic              busy;
    logic              conflict;
    logic              err;

    redirect_route_ctrl #(
        .N_TARG_PORT   (NT),
        .N_INIT_PORT   (NI),
        .LOG_N_INIT    (LW),
        .DRAIN_TIMEOUT (TO)
    ) u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .redirect_valid_i     (vld),
        .source_i             (src_v),
        .target_i             (tgt_v),
        .quiesce_req_o        (q_req),
        .quiesce_ack_i        (ack),
        .route_override_en_o  (ov_en),
        .route_override_tgt_o (ov_tgt),
        .busy_o               (busy),
        .conflict_o           (conflict),
        .err_timeout_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- request-level model ----------------
    // pend_kind: 0 = nothing, 1 = install waiting, 2 = removal waiting
    int         pend_kind [NT];
    int         sh_src [NT];
    int         sh_tgt [NT];
    logic       prev [NT];
    logic       m_en [NI];
    int         m_tgt [NI];
    int         m_owner [NI];
    logic       m_err;
    logic       m_conf;
    logic       m_active;
    logic       m_ready;     // drain acknowledged, write happens on next edge
    int         m_wait;
    int         m_p, m_src, m_opt, m_kind;

    task automatic model_reset();
        for (int p = 0; p < NT; p++) begin
            pend_kind[p] = 0; sh_src[p] = 0; sh_tgt[p] = 0; prev[p] = 1'b0;
        end
        for (int i = 0; i < NI; i++) begin
            m_en[i] = 1'b0; m_tgt[i] = 0; m_owner[i] = 0;
        end
        m_err = 1'b0; m_conf = 1'b0; m_active = 1'b0; m_ready = 1'b0;
        m_wait = 0; m_p = 0; m_src = 0; m_opt = 0; m_kind = 0;
    endtask

    task automatic model_step();
        int pick;
        m_conf = 1'b0;
        if (m_active) begin
            if (m_ready) begin
                if (m_kind == 1) begin
                    if (m_en[m_src] && m_owner[m_src] != m_p) m_conf = 1'b1;
                    m_en[m_src] = 1'b1; m_tgt[m_src] = m_opt; m_owner[m_src] = m_p;
                end else if (m_en[m_src] && m_owner[m_src] == m_p) begin
                    m_en[m_src] = 1'b0;
                end
                m_active = 1'b0; m_ready = 1'b0;
            end else if (ack[m_src]) begin
                m_ready = 1'b1;
            end else if (m_wait == TO) begin
                m_active = 1'b0; m_err = 1'b1;
            end else begin
                m_wait++;
            end
        end else begin
            pick = -1;
            for (int p = NT - 1; p >= 0; p--) if (pend_kind[p] != 0) pick = p;
            if (pick >= 0) begin
                m_kind = pend_kind[pick];
                pend_kind[pick] = 0;
                if (sh_src[pick] >= NI) begin
                    m_err = 1'b1;
                end else begin
                    m_active = 1'b1; m_wait = 0;
                    m_p = pick; m_src = sh_src[pick]; m_opt = sh_tgt[pick];
                end
            end
        end
        for (int p = 0; p < NT; p++) begin
            if (vld[p] && !prev[p]) begin
                pend_kind[p] = 1;
                sh_src[p] = int'(src_v[p*LW +: LW]);
                sh_tgt[p] = int'(tgt_v[p*LW +: LW]);
            end else if (!vld[p] && prev[p]) begin
                pend_kind[p] = 2;
            end
            prev[p] = vld[p];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    int req_hi_cnt  = 0;
    int conf_cnt    = 0;

    initial begin
        logic [NI-1:0]    e_req;
        logic [NI-1:0]    e_en;
        logic [NI*LW-1:0] e_tgt;
        forever begin
            @(negedge clk);
            e_req = '0;
            if (m_active) e_req[m_src] = 1'b1;
            for (int i = 0; i < NI; i++) begin
                e_en[i] = m_en[i];
                e_tgt[i*LW +: LW] = LW'(m_tgt[i]);
            end
            check("quiesce_req", 32'(q_req), 32'(e_req));
            check("override_en", 32'(ov_en), 32'(e_en));
            check("override_tgt", 32'(ov_tgt), 32'(e_tgt));
            check("busy", 32'(busy), 32'(m_active));
            check("conflict", 32'(conflict), 32'(m_conf));
            check("err_timeout", 32'(err), 32'(m_err));
            if (q_req != '0) req_hi_cnt++;
            if (conflict) conf_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int p, input logic v, input int s, input int t);
        vld[p] = v;
        src_v[p*LW +: LW] = LW'(s);
        tgt_v[p*LW +: LW] = LW'(t);
    endtask

    initial begin
        int r0, c0;
        rst_n = 1'b0; vld = '0; src_v = '0; tgt_v = '0; ack = '1;
        tick(2);
        check("rst_outputs", {q_req, ov_en, ov_tgt, busy, conflict, err}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: p2 installs src1 -> tgt3, two cycles of quiesce request
        r0 = req_hi_cnt;
        set_port(2, 1'b1, 1, 3);
        tick(6);
        check("t1_en", 32'(ov_en), 32'h2);
        check("t1_tgt1", 32'(ov_tgt[2 +: 2]), 32'd3);
        check("t1_req_cycles", req_hi_cnt - r0, 32'd2);

        // 2: p2 falls -> entry withdrawn, no conflict
        c0 = conf_cnt;
        set_port(2, 1'b0, 1, 3);
        tick(6);
        check("t2_en", 32'(ov_en), 32'h0);
        check("t2_conflict", conf_cnt - c0, 32'd0);

        // 3: p0 and p4 rise together on src0
        c0 = conf_cnt;
        set_port(0, 1'b1, 0, 1);
        set_port(4, 1'b1, 0, 2);
        tick(10);
        check("t3_en", 32'(ov_en), 32'h1);
        check("t3_tgt0", 32'(ov_tgt[0 +: 2]), 32'd2);
        check("t3_conflict", conf_cnt - c0, 32'd1);

        // 4: drain never acknowledged -> timeout after 6 request cycles
        ack = '0;
        r0 = req_hi_cnt;
        set_port(5, 1'b1, 3, 1);
        tick(12);
        check("t4_err", 32'(err), 32'd1);
        check("t4_req_cycles", req_hi_cnt - r0, 32'd6);
        check("t4_en", 32'(ov_en), 32'h1);
        ack = '1;

        // 5: p1 installs src2, p3 steals it, p1 falls -> p3's entry remains
        c0 = conf_cnt;
        set_port(1, 1'b1, 2, 1);
        tick(6);
        set_port(3, 1'b1, 2, 3);
        tick(6);
        set_port(1, 1'b0, 2, 1);
        tick(6);
        check("t5_en", 32'(ov_en), 32'h5);
        check("t5_tgt2", 32'(ov_tgt[4 +: 2]), 32'd3);
        check("t5_conflict", conf_cnt - c0, 32'd1);

        // 6: reset while quiescing
        ack = '0;
        set_port(6, 1'b1, 1, 2);
        tick(3);
        check("t6_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        vld = '0;
        #1;
        check("t6_req_async", 32'(q_req), 32'd0);
        check("t6_rst_outputs", {q_req, ov_en, ov_tgt, busy, conflict, err}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        ack = '1;
        tick(2);
        set_port(6, 1'b1, 1, 2);
        tick(6);
        check("t6_en", 32'(ov_en), 32'h2);
        check("t6_tgt1", 32'(ov_tgt[2 +: 2]), 32'd2);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
